// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
// Contents:
//   fetch_state_t     - fetch FSM state encoding
//   NOP_INSTR         - canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT  - default reset PC
//   *_LSB/_MSB/_BIT   - bit positions of the fields handed to the control unit
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7_5_BIT = 30;
    localparam int OP_5_BIT     = 5;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch unit (purely combinational).
// Ports:
//   pc         in   current PC
//   pc_src     in   1 = take pc_target instead of pc + 4
//   pc_target  in   branch/jump target from the datapath
//   pc_plus4   out  pc + 4 (wraps modulo 2^XLEN)
//   pc_next    out  selected next PC
//   misaligned out  selected target is not word aligned
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);

    assign pc_plus4   = pc + XLEN'(4);
    assign pc_next    = pc_src ? pc_target : pc_plus4;
    // Only a taken redirect can misalign; sequential PCs stay aligned.
    assign misaligned = pc_src & (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready
// handshake, and presents the registered instruction plus decode fields.
// Optional build macro: FETCH_TIMEOUT_EN bounds the WAIT state to
// TIMEOUT_CYCLES cycles; on expiry the unit flags fetch_err and halts.
// Ports:
//   clk, rst_n              clock / synchronous active-low reset
//   imem_req, imem_addr     fetch request and address (= pc)
//   imem_ready, imem_rdata  memory response (rdata valid with ready)
//   pc_src, pc_target       redirect control and target, sampled on consume
//   stall                   hold current instruction in ISSUE
//   instr_valid, instr, pc, pc_plus4   issued instruction and its PC
//   op, funct3, funct7_5, op_5         decode fields sliced from instr
//   fetch_err               sticky error (misaligned target / timeout)
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = XLEN'(RESET_PC_DEFAULT),
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic            op_5,
    output logic            fetch_err
);

    // A zero bound would halt on the first WAIT cycle; reject it early.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic            err_reg, err_next;

    logic [XLEN-1:0] pc_sel;
    logic            target_misaligned;

`ifdef FETCH_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
`endif

    pc_next_sel #(
        .XLEN(XLEN)
    ) u_pc_next_sel (
        .pc         (pc_reg),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .pc_plus4   (pc_plus4),
        .pc_next    (pc_sel),
        .misaligned (target_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= XLEN'(NOP_INSTR);
            err_reg   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            err_reg   <= err_next;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_reg <= to_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        err_next   = err_reg;
`ifdef FETCH_TIMEOUT_EN
        to_cnt_next = to_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
`ifdef FETCH_TIMEOUT_EN
                // Cleared here so every WAIT episode starts counting at zero.
                to_cnt_next = '0;
`endif
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    state_next = ST_ISSUE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (to_cnt_reg == TO_LAST) begin
                        err_next   = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        to_cnt_next = to_cnt_reg + 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    if (target_misaligned) begin
                        // Keep the faulting instruction's PC for debug.
                        err_next   = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_sel;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    assign imem_req    = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == ST_ISSUE);
    assign instr       = instr_reg;
    assign pc          = pc_reg;
    assign fetch_err   = err_reg;

    assign op       = instr_reg[OP_MSB:OP_LSB];
    assign funct3   = instr_reg[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7_5 = instr_reg[FUNCT7_5_BIT];
    assign op_5     = instr_reg[OP_5_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory
// with chosen latencies and tracks the expected PC at transaction level.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        op_5;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .op          (op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op_5        (op_5),
        .fetch_err   (fetch_err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    logic [31:0] rnd_word;
    logic [31:0] rnd_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive reset for two edges, check reset state, release; returns in REQ.
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_instr", instr,                32'h0000_0013);
        rst_n = 1'b1;
        @(negedge clk);
        exp_pc = 32'h0;
        $display("reset done pc=%h", pc);
    endtask

    // One fetch transaction: lat wait cycles, then issue, stalls, consume.
    task automatic do_fetch(input int lat, input logic [31:0] word, input int stalls,
                            input logic src, input logic [31:0] tgt);
        logic [31:0] exp_op, exp_f3, exp_f75, exp_op5;
        exp_op  = {25'b0, word[6:0]};
        exp_f3  = {29'b0, word[14:12]};
        exp_f75 = {31'b0, word[30]};
        exp_op5 = {31'b0, word[5]};
        chk("req_first",  {31'b0, imem_req},    32'd1);
        chk("addr_first", imem_addr,            exp_pc);
        chk("novalid",    {31'b0, instr_valid}, 32'd0);
        for (int k = 0; k < lat; k++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("req_wait",  {31'b0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr,         exp_pc);
            chk("wait_nov",  {31'b0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("iss_valid", {31'b0, instr_valid}, 32'd1);
        chk("iss_req",   {31'b0, imem_req},    32'd0);
        chk("iss_instr", instr,                word);
        chk("iss_pc",    pc,                   exp_pc);
        chk("iss_pc4",   pc_plus4,             exp_pc + 32'd4);
        chk("iss_op",    {25'b0, op},          exp_op);
        chk("iss_f3",    {29'b0, funct3},      exp_f3);
        chk("iss_f75",   {31'b0, funct7_5},    exp_f75);
        chk("iss_op5",   {31'b0, op_5},        exp_op5);
        for (int s = 0; s < stalls; s++) begin
            stall      = 1'b1;
            pc_src     = 1'($urandom);
            pc_target  = $urandom;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
            chk("stl_valid", {31'b0, instr_valid}, 32'd1);
            chk("stl_instr", instr,                word);
            chk("stl_pc",    pc,                   exp_pc);
            chk("stl_req",   {31'b0, imem_req},    32'd0);
        end
        stall      = 1'b0;
        imem_ready = 1'b0;
        pc_src     = src;
        pc_target  = tgt;
        @(negedge clk);
        pc_src = 1'b0;
        if (src && (tgt[1:0] != 2'b00)) begin
            chk("mis_err",   {31'b0, fetch_err},   32'd1);
            chk("mis_req",   {31'b0, imem_req},    32'd0);
            chk("mis_valid", {31'b0, instr_valid}, 32'd0);
            chk("mis_pc",    pc,                   exp_pc);
        end else begin
            exp_pc = src ? tgt : exp_pc + 32'd4;
            chk("ok_err", {31'b0, fetch_err}, 32'd0);
        end
        $display("fetch word=%h lat=%0d stalls=%0d src=%0d tgt=%h next_pc=%h",
                 word, lat, stalls, src, tgt, exp_pc);
    endtask

    initial begin
        do_reset();

        // Zero-latency memory: addresses 0, 4, 8.
        do_fetch(0, 32'h0010_0093, 0, 1'b0, 32'h0);
        do_fetch(0, 32'h4020_81b3, 0, 1'b0, 32'h0);
        do_fetch(0, 32'h0020_a023, 0, 1'b0, 32'h0);

        // Ready delayed three cycles: request held four cycles.
        do_fetch(3, 32'h0000_006f, 0, 1'b0, 32'h0);

        // Redirect to 0x100, then check the fetch there.
        do_fetch(0, 32'h0080_00ef, 0, 1'b1, 32'h0000_0100);
        do_fetch(1, 32'h0000_0013, 0, 1'b0, 32'h0);

        // Five-cycle stall with pc_src toggling underneath.
        do_fetch(0, 32'h00b5_0533, 5, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        do_fetch(0, 32'h0000_0067, 0, 1'b1, 32'hFFFF_FFFC);
        do_fetch(2, 32'h0000_0013, 0, 1'b0, 32'h0);
        chk("wrap_pc", exp_pc, 32'h0);
        do_fetch(0, 32'h0000_0013, 0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            rnd_word = $urandom;
            rnd_tgt  = $urandom & 32'hFFFF_FFFC;
            do_fetch(int'($urandom_range(0, 4)), rnd_word, int'($urandom_range(0, 3)),
                     1'($urandom), rnd_tgt);
        end

        // Misaligned target: halt, stay halted, then one-cycle reset.
        do_fetch(1, 32'h0000_0063, 1, 1'b1, 32'h0000_0102);
        for (int h = 0; h < 4; h++) begin
            imem_ready = 1'($urandom);
            @(negedge clk);
            chk("halt_req",   {31'b0, imem_req},    32'd0);
            chk("halt_valid", {31'b0, instr_valid}, 32'd0);
            chk("halt_err",   {31'b0, fetch_err},   32'd1);
        end
        imem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst1_pc",  pc,                 32'h0);
        chk("rst1_err", {31'b0, fetch_err}, 32'd0);
        chk("rst1_req", {31'b0, imem_req},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_pc = 32'h0;
        $display("halt recovered by reset");
        do_fetch(0, 32'h0000_0013, 0, 1'b0, 32'h0);

        // Reset in the middle of a pending fetch aborts it.
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_pc",  pc,                32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_pc = 32'h0;
        $display("mid-fetch reset done");

        // Memory never answers.
`ifdef FETCH_TIMEOUT_EN
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            chk("to_req", {31'b0, imem_req},  32'd1);
            chk("to_err", {31'b0, fetch_err}, 32'd0);
        end
        @(negedge clk);
        chk("to_fired",   {31'b0, fetch_err}, 32'd1);
        chk("to_req_off", {31'b0, imem_req},  32'd0);
        $display("timeout after 16 wait cycles");
`else
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            chk("nb_req",  {31'b0, imem_req},  32'd1);
            chk("nb_addr", imem_addr,          32'h0);
            chk("nb_err",  {31'b0, fetch_err}, 32'd0);
        end
        $display("unbounded wait held request for 40 cycles");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end for the RISC-V core: owns the PC register, fetches from instruction memory over a req/ready handshake and presents the decoded fields (op, funct3, funct7_5, op_5) to the control unit. It consumes the control unit's PC_src and the datapath branch/jump target to select the next PC. It is the producer end of the control unit's decode interface. A small FSM replaces the single-cycle assumption so the core tolerates multi-cycle memory.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max WAIT cycles before fetch error (only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
imem_req  out  1  fetch request, held until accepted
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  memory returns data this cycle
imem_rdata  in  XLEN  instruction word, valid when imem_ready
pc_src  in  1  from control unit: 1 = take pc_target
pc_target  in  XLEN  branch/jump target from datapath
stall  in  1  hold current instruction in ISSUE
instr_valid  out  1  instr and fields valid
instr  out  XLEN  registered instruction word
pc  out  XLEN  PC of instr
pc_plus4  out  XLEN  pc + 4, for JAL/JALR link
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7_5  out  1  instr[30]
op_5  out  1  instr[5]
fetch_err  out  1  sticky error flag

Behaviour:
- Reset: all state sampled on clk rising edge when rst_n=0. Mid-operation reset aborts any fetch. After reset: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, instr_valid=0, fetch_err=0.
- States: IDLE, REQ, WAIT, ISSUE, HALT.
- IDLE -> REQ unconditionally on the next cycle (one bubble after reset).
- REQ: imem_req=1, imem_addr=pc. If imem_ready in the same cycle, latch imem_rdata into instr and go to ISSUE. Otherwise go to WAIT.
- WAIT: imem_req=1. imem_addr stays stable. On imem_ready, latch instr and go to ISSUE.
- ISSUE: instr_valid=1. imem_req=0.
  - If stall=1, remain in ISSUE with instr and pc unchanged.
  - If stall=0, update pc to (pc_src ? pc_target : pc+4) and go to REQ.
  - pc_src and pc_target are sampled only in the ISSUE cycle with stall=0.
- Best-case throughput: one instruction per 2 cycles (REQ hit -> ISSUE). Latency from REQ to instr_valid: 1 cycle plus memory wait.
- Decoded fields are combinational slices of the registered instr; they are meaningful only while instr_valid=1.
- pc_plus4 = pc + 4, modulo 2^XLEN. PC wraps from 32'hFFFF_FFFC to 0 with no error.
- Misaligned target: if pc_src=1 and pc_target[1:0]!=0 in a consuming ISSUE cycle:
  - set fetch_err=1, pc unchanged, go to HALT.
- HALT: imem_req=0, instr_valid=0. Exit only via reset.
- imem_ready outside REQ/WAIT is ignored.

Optional Feature:
FETCH_TIMEOUT_EN: when defined, a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without imem_ready, set fetch_err=1 and go to HALT. When undefined, WAIT has no bound and no counter exists.

Decomposition:
- Shared package riscv_pkg: fetch state enum, NOP constant 32'h0000_0013, opcode field bit positions, RESET_PC default.
- One natural sub-module: pc_next_sel. Combinational; computes pc+4, muxes pc_target, flags misalignment. It is instantiated in fetch_unit, which keeps the FSM and registers.

Test Plan:
- Reset then imem_ready tied 1 -> imem_addr sequence 0, 4, 8; instr_valid on every second cycle; op/funct3 match the supplied words.
- imem_ready delayed 3 cycles -> imem_req held 4 cycles with imem_addr constant; instr_valid asserted one cycle after ready.
- In ISSUE, pc_src=1, pc_target=32'h0000_0100 -> next imem_addr=32'h100; pc_plus4 of the following instruction=32'h104.
- stall=1 for 5 cycles in ISSUE -> instr, pc and instr_valid stable; no imem_req; pc_src toggling during the stall is ignored.
- pc_src=1, pc_target=32'h0000_0102 -> fetch_err=1, HALT, imem_req=0; rst_n=0 for one cycle -> pc=RESET_PC, fetch_err=0.
- With FETCH_TIMEOUT_EN, imem_ready never asserted -> fetch_err rises after exactly 16 WAIT cycles. Without the macro, imem_req stays high indefinitely.
